decision_scan_ctrl: RTL and testbench
=====================================

Name: decision_scan_ctrl

Overview:
- Parametrised, multi-cycle successor of the bin-level decision unit in the SAT bin engine.
- Scans the per-variable value vector in CHUNK-wide slices and selects the lowest-index unassigned variable.
- Polarity of the decision comes from a saved-phase register per variable.
- Tracks the decision level, with backtrack load, saturation and overflow flag; reports "all assigned" when no free variable exists.

Parameters:
- NUM_VARS, 24, number of variables in the bin.
- CHUNK, 8, variables examined per scan cycle; must divide NUM_VARS.
- LEVEL_W, 16, width of the decision-level counter.
- DEFAULT_PHASE, 0, reset value of every saved-phase bit.
- IDX_W (localparam), $clog2(NUM_VARS), width of the decision index.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- start_i  in  1  request one decision; accepted only in IDLE
- vars_value_i  in  NUM_VARS*3  per-variable value word; var i occupies [3i+2:3i]; bits [3i+2:3i+1]: 00 free, 01 false, 10 true, 11 assigned (phase unchanged); bit 3i ignored
- phase_save_i  in  1  capture polarities of assigned vars into saved-phase register
- bkt_valid_i  in  1  backtrack: load level, abort scan
- bkt_level_i  in  LEVEL_W  backtrack target level
- dec_onehot_o  out  NUM_VARS  one-hot decided variable; all-zero if none
- dec_idx_o  out  IDX_W  index of decided variable
- dec_phase_o  out  1  polarity assigned to decided variable
- done_o  out  1  one-cycle pulse: decision result valid
- all_assigned_o  out  1  set with done_o when no free var found
- busy_o  out  1  high while scanning
- cur_level_o  out  LEVEL_W  current decision level
- level_ovf_o  out  1  sticky: increment attempted at max level

Behaviour:
- Reset: state IDLE; all outputs 0, including cur_level_o and level_ovf_o; chunk pointer 0; every phase_q bit = DEFAULT_PHASE.
- FSM states: IDLE, SCAN, DONE.
- IDLE -> SCAN: on start_i with bkt_valid_i low.
  - At that edge: snapshot vars_value_i, pointer = 0.
  - At that edge: clear dec_onehot_o/dec_idx_o/dec_phase_o/all_assigned_o.
- SCAN:
  - busy_o = 1.
  - Each cycle examines snapshot chunk [ptr*CHUNK, ptr*CHUNK+CHUNK-1] and finds the lowest free var.
  - If found, at the edge ending that cycle:
    - register one-hot, idx and dec_phase_o = phase_q[idx];
    - cur_level += 1;
    - go DONE.
  - If not found and this is the last chunk, at that edge:
    - all_assigned_o = 1, one-hot = 0, level unchanged;
    - go DONE.
  - Otherwise ptr += 1 and stay in SCAN.
- DONE: done_o = 1 for exactly this cycle, then IDLE.
- Latency: start seen in cycle 0; free var in chunk k -> done_o in cycle k+2. Maximum is NUM_VARS/CHUNK+1.
- Results (one-hot, idx, phase, all_assigned) hold until the next accepted start.
- start_i in SCAN/DONE is ignored and is not queued.
- Level saturation: at 2^LEVEL_W-1 an increment leaves the level unchanged and sets level_ovf_o. The decision itself is still reported.
- bkt_valid_i, any state:
  - cur_level = bkt_level_i; level_ovf_o cleared.
  - In SCAN it aborts to IDLE: no done_o, results cleared to 0.
  - It overrides a simultaneous start_i and a simultaneous level increment.
- phase_save_i, any state: for each var, 01 -> phase_q = 0, 10 -> phase_q = 1; 00/11 keep.
  - A decision registered on the same edge uses phase_q before update.
- The value vector is sampled only at start acceptance; later changes do not affect the scan in progress.
- rst mid-scan: returns to the reset state at the next edge; no done_o.

Test Plan:
- NUM_VARS=24, CHUNK=8, all free, start -> done_o cycle 2, dec_idx_o=0, one-hot 0x000001, phase 0, cur_level 1.
- Vars 0..16 assigned (01), var 17 free, start -> done_o cycle 4, dec_idx_o=17, one-hot 0x020000, cur_level +1.
- All 24 vars = 10, start -> done_o cycle 4, all_assigned_o=1, one-hot 0, level unchanged.
- Var 5 = 10, phase_save_i; then var 5 = 00 with vars 0..4 assigned, start -> dec_idx_o=5, dec_phase_o=1.
- Start with vars 0..15 assigned; bkt_valid_i level 3 in cycle 2 -> no done_o, busy_o low next cycle, cur_level_o=3, outputs 0.
- LEVEL_W=2, four decisions -> levels 1,2,3,3, level_ovf_o=1 after the fourth; bkt to 0 clears level_ovf_o.

Source files
------------

// File: rtl/decision_scan_ctrl.sv
// Picks the lowest-index free variable by scanning a snapshot of the value vector CHUNK vars per cycle.
// Latency: free var in chunk k -> done_o k+2 cycles after start; start ignored while busy; bkt_valid_i aborts.
module decision_scan_ctrl #(
    parameter int NUM_VARS      = 24,
    parameter int CHUNK         = 8,
    parameter int LEVEL_W       = 16,
    parameter int DEFAULT_PHASE = 0,
    localparam int IDX_W        = $clog2(NUM_VARS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [NUM_VARS*3-1:0] vars_value_i,
    input  logic                  phase_save_i,
    input  logic                  bkt_valid_i,
    input  logic [LEVEL_W-1:0]    bkt_level_i,
    output logic [NUM_VARS-1:0]   dec_onehot_o,
    output logic [IDX_W-1:0]      dec_idx_o,
    output logic                  dec_phase_o,
    output logic                  done_o,
    output logic                  all_assigned_o,
    output logic                  busy_o,
    output logic [LEVEL_W-1:0]    cur_level_o,
    output logic                  level_ovf_o
);
    localparam int NUM_CHUNKS = NUM_VARS / CHUNK;
    localparam int PTR_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;
    localparam logic [PTR_W-1:0]   LAST_PTR  = PTR_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                  state;
    logic [PTR_W-1:0]        ptr;
    logic [2*NUM_VARS-1:0]   snap;
    logic [NUM_VARS-1:0]     phase_q;
    logic [2*NUM_VARS-1:0]   val2;
    logic [NUM_VARS-1:0]     lsb_ignored;
    logic                    unused_lsb;
    logic                    hit;
    logic [IDX_W-1:0]        hit_idx;

    // Only the two status bits of each 3-bit word carry meaning.
    always_comb begin
        val2        = '0;
        lsb_ignored = '0;
        for (int i = 0; i < NUM_VARS; i++) begin
            val2[2*i +: 2] = vars_value_i[3*i+1 +: 2];
            lsb_ignored[i] = vars_value_i[3*i];
        end
    end

    assign unused_lsb = ^lsb_ignored;

    // Downward loop so the lowest free index in the chunk wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int j = CHUNK - 1; j >= 0; j--) begin
            if (snap[2*(int'(ptr)*CHUNK + j) +: 2] == 2'b00) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(int'(ptr)*CHUNK + j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            ptr            <= '0;
            snap           <= '0;
            phase_q        <= {NUM_VARS{1'(DEFAULT_PHASE)}};
            dec_onehot_o   <= '0;
            dec_idx_o      <= '0;
            dec_phase_o    <= 1'b0;
            done_o         <= 1'b0;
            all_assigned_o <= 1'b0;
            busy_o         <= 1'b0;
            cur_level_o    <= '0;
            level_ovf_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;

            if (phase_save_i) begin
                for (int i = 0; i < NUM_VARS; i++) begin
                    if (val2[2*i +: 2] == 2'b01) phase_q[i] <= 1'b0;
                    else if (val2[2*i +: 2] == 2'b10) phase_q[i] <= 1'b1;
                end
            end

            if (bkt_valid_i) begin
                cur_level_o <= bkt_level_i;
                level_ovf_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start_i && !bkt_valid_i) begin
                        state          <= SCAN;
                        busy_o         <= 1'b1;
                        snap           <= val2;
                        ptr            <= '0;
                        dec_onehot_o   <= '0;
                        dec_idx_o      <= '0;
                        dec_phase_o    <= 1'b0;
                        all_assigned_o <= 1'b0;
                    end
                end
                SCAN: begin
                    if (bkt_valid_i) begin
                        state          <= IDLE;
                        busy_o         <= 1'b0;
                        dec_onehot_o   <= '0;
                        dec_idx_o      <= '0;
                        dec_phase_o    <= 1'b0;
                        all_assigned_o <= 1'b0;
                    end else if (hit) begin
                        state        <= DONE;
                        busy_o       <= 1'b0;
                        done_o       <= 1'b1;
                        dec_onehot_o <= NUM_VARS'(1) << hit_idx;
                        dec_idx_o    <= hit_idx;
                        dec_phase_o  <= phase_q[hit_idx];
                        if (cur_level_o == LEVEL_MAX) level_ovf_o <= 1'b1;
                        else cur_level_o <= cur_level_o + 1'b1;
                    end else if (ptr == LAST_PTR) begin
                        state          <= DONE;
                        busy_o         <= 1'b0;
                        done_o         <= 1'b1;
                        all_assigned_o <= 1'b1;
                        dec_onehot_o   <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_decision_scan_ctrl.sv
// Bench for decision_scan_ctrl: directed scenarios plus random decisions against a per-variable model.
module tb_decision_scan_ctrl;
    localparam int NV = 24;
    localparam int CH = 8;

    logic        clk = 0;
    logic        rst = 1;
    logic        start = 0, start2 = 0;
    logic [71:0] vars_value = '0;
    logic        phase_save = 0;
    logic        bkt_valid = 0, bkt_valid2 = 0;
    logic [15:0] bkt_level = '0;
    logic [1:0]  bkt_level2 = '0;
    logic [23:0] dec_onehot, dec_onehot2;
    logic [4:0]  dec_idx, dec_idx2;
    logic        dec_phase, dec_phase2, done, done2, all_assigned, all_assigned2, busy, busy2;
    logic [15:0] cur_level;
    logic [1:0]  cur_level2;
    logic        level_ovf, level_ovf2;

    int n_tests = 0;
    int n_fail  = 0;
    int lvl     = 0;
    bit ovf     = 0;
    bit ph [NV];

    always #5 clk = ~clk;

    decision_scan_ctrl #(.NUM_VARS(NV), .CHUNK(CH), .LEVEL_W(16), .DEFAULT_PHASE(0)) dut (
        .clk(clk), .rst(rst), .start_i(start), .vars_value_i(vars_value),
        .phase_save_i(phase_save), .bkt_valid_i(bkt_valid), .bkt_level_i(bkt_level),
        .dec_onehot_o(dec_onehot), .dec_idx_o(dec_idx), .dec_phase_o(dec_phase),
        .done_o(done), .all_assigned_o(all_assigned), .busy_o(busy),
        .cur_level_o(cur_level), .level_ovf_o(level_ovf));

    decision_scan_ctrl #(.NUM_VARS(NV), .CHUNK(CH), .LEVEL_W(2), .DEFAULT_PHASE(0)) dut2 (
        .clk(clk), .rst(rst), .start_i(start2), .vars_value_i(vars_value),
        .phase_save_i(phase_save), .bkt_valid_i(bkt_valid2), .bkt_level_i(bkt_level2),
        .dec_onehot_o(dec_onehot2), .dec_idx_o(dec_idx2), .dec_phase_o(dec_phase2),
        .done_o(done2), .all_assigned_o(all_assigned2), .busy_o(busy2),
        .cur_level_o(cur_level2), .level_ovf_o(level_ovf2));

    function automatic int first_free(input logic [71:0] v);
        for (int i = 0; i < NV; i++)
            if (v[3*i+1 +: 2] == 2'b00) return i;
        return -1;
    endfunction

    function automatic int exp_latency(input int ff);
        return (ff >= 0) ? ff / CH + 2 : NV / CH + 1;
    endfunction

    // Random vector; each var is free with probability 1/free_odds.
    function automatic logic [71:0] rand_vec(input int free_odds);
        logic [71:0] v = '0;
        for (int i = 0; i < NV; i++) begin
            v[3*i] = 1'($urandom);
            if ($urandom_range(0, free_odds - 1) == 0) v[3*i+1 +: 2] = 2'b00;
            else v[3*i+1 +: 2] = 2'($urandom_range(1, 3));
        end
        return v;
    endfunction

    function automatic void model_decide(input int ff);
        if (ff >= 0) begin
            if (lvl == 65535) ovf = 1;
            else lvl++;
        end
    endfunction

    // Issues one start at a negedge and waits (bounded) for done; lat = -1 on timeout.
    task automatic run_dec(input logic [71:0] vec, input bit second, output int lat);
        @(negedge clk);
        vars_value = vec;
        if (second) start2 = 1; else start = 1;
        @(negedge clk);
        start = 0; start2 = 0;
        vars_value = rand_vec(2);
        lat = 1;
        while (!(second ? done2 : done) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!(second ? done2 : done)) lat = -1;
    endtask

    task automatic do_phase_save(input logic [71:0] vec);
        @(negedge clk);
        vars_value = vec;
        phase_save = 1;
        for (int i = 0; i < NV; i++) begin
            if (vec[3*i+1 +: 2] == 2'b01) ph[i] = 0;
            else if (vec[3*i+1 +: 2] == 2'b10) ph[i] = 1;
        end
        @(negedge clk);
        phase_save = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        lvl = 0; ovf = 0;
        for (int i = 0; i < NV; i++) ph[i] = 0;
        n_tests += 6;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        if (cur_level !== 16'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", cur_level); end
        if (level_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", level_ovf); end
        if (dec_onehot !== 24'd0 || dec_idx !== 5'd0) begin n_fail++; $display("FAIL reset_result got %h/%0d want 0/0", dec_onehot, dec_idx); end
        if (all_assigned !== 1'b0 || dec_phase !== 1'b0) begin n_fail++; $display("FAIL reset_flags got %b%b want 00", all_assigned, dec_phase); end
    endtask

    task automatic test_all_free();
        int lat;
        run_dec(72'd0, 0, lat);
        model_decide(0);
        n_tests += 5;
        if (lat !== 2) begin n_fail++; $display("FAIL allfree_latency got %0d want 2", lat); end
        if (dec_idx !== 5'd0) begin n_fail++; $display("FAIL allfree_idx got %0d want 0", dec_idx); end
        if (dec_onehot !== 24'h000001) begin n_fail++; $display("FAIL allfree_onehot got %h want 000001", dec_onehot); end
        if (dec_phase !== 1'b0) begin n_fail++; $display("FAIL allfree_phase got %b want 0", dec_phase); end
        if (cur_level !== 16'(lvl)) begin n_fail++; $display("FAIL allfree_level got %0d want %0d", cur_level, lvl); end
    endtask

    task automatic test_var17();
        int lat;
        logic [71:0] v = '0;
        for (int i = 0; i < 17; i++) v[3*i +: 3] = 3'b010;
        run_dec(v, 0, lat);
        model_decide(17);
        n_tests += 4;
        if (lat !== 4) begin n_fail++; $display("FAIL var17_latency got %0d want 4", lat); end
        if (dec_idx !== 5'd17) begin n_fail++; $display("FAIL var17_idx got %0d want 17", dec_idx); end
        if (dec_onehot !== 24'h020000) begin n_fail++; $display("FAIL var17_onehot got %h want 020000", dec_onehot); end
        if (cur_level !== 16'(lvl)) begin n_fail++; $display("FAIL var17_level got %0d want %0d", cur_level, lvl); end
        repeat (3) @(negedge clk);
        n_tests++;
        if (dec_idx !== 5'd17 || done !== 1'b0) begin n_fail++; $display("FAIL var17_hold got idx %0d done %b want 17/0", dec_idx, done); end
    endtask

    task automatic test_all_assigned();
        int lat;
        logic [71:0] v = '0;
        for (int i = 0; i < NV; i++) v[3*i +: 3] = 3'b100;
        run_dec(v, 0, lat);
        n_tests += 4;
        if (lat !== 4) begin n_fail++; $display("FAIL allasg_latency got %0d want 4", lat); end
        if (all_assigned !== 1'b1) begin n_fail++; $display("FAIL allasg_flag got %b want 1", all_assigned); end
        if (dec_onehot !== 24'd0) begin n_fail++; $display("FAIL allasg_onehot got %h want 0", dec_onehot); end
        if (cur_level !== 16'(lvl)) begin n_fail++; $display("FAIL allasg_level got %0d want %0d", cur_level, lvl); end
    endtask

    task automatic test_phase_save();
        int lat;
        logic [71:0] v = '0;
        v[3*5 +: 3] = 3'b100;
        do_phase_save(v);
        v = rand_vec(1);
        for (int i = 0; i < 5; i++) v[3*i +: 3] = 3'b011;
        v[3*5 +: 3] = 3'b001;
        run_dec(v, 0, lat);
        model_decide(5);
        n_tests += 3;
        if (dec_idx !== 5'd5) begin n_fail++; $display("FAIL phase_idx got %0d want 5", dec_idx); end
        if (dec_phase !== 1'b1) begin n_fail++; $display("FAIL phase_value got %b want 1", dec_phase); end
        if (lat !== 2) begin n_fail++; $display("FAIL phase_latency got %0d want 2", lat); end
    endtask

    task automatic test_backtrack();
        logic [71:0] v = '0;
        int dones = 0;
        for (int i = 0; i < 16; i++) v[3*i +: 3] = 3'b010;
        @(negedge clk); vars_value = v; start = 1;        // cycle 0
        @(negedge clk); start = 0;                        // cycle 1
        @(negedge clk); bkt_valid = 1; bkt_level = 16'd3; // cycle 2
        @(negedge clk); bkt_valid = 0;                    // cycle 3
        lvl = 3; ovf = 0;
        n_tests += 4;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL bkt_busy got %b want 0", busy); end
        if (cur_level !== 16'd3) begin n_fail++; $display("FAIL bkt_level got %0d want 3", cur_level); end
        if (dec_onehot !== 24'd0 || dec_idx !== 5'd0 || all_assigned !== 1'b0) begin n_fail++; $display("FAIL bkt_results got %h/%0d/%b want 0", dec_onehot, dec_idx, all_assigned); end
        for (int c = 0; c < 5; c++) begin
            if (done) dones++;
            @(negedge clk);
        end
        if (dones !== 0) begin n_fail++; $display("FAIL bkt_nodone got %0d pulses want 0", dones); end
        // start together with backtrack: backtrack wins
        vars_value = 72'd0; start = 1; bkt_valid = 1; bkt_level = 16'd9;
        @(negedge clk); start = 0; bkt_valid = 0;
        lvl = 9;
        n_tests += 2;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL bkt_override_busy got %b want 0", busy); end
        if (cur_level !== 16'd9) begin n_fail++; $display("FAIL bkt_override_level got %0d want 9", cur_level); end
    endtask

    task automatic test_reset_midscan();
        logic [71:0] v = '0;
        int dones = 0;
        for (int i = 0; i < NV; i++) v[3*i +: 3] = 3'b110;
        @(negedge clk); vars_value = v; start = 1;
        @(negedge clk); start = 0;
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        lvl = 0; ovf = 0;
        for (int i = 0; i < NV; i++) ph[i] = 0;
        for (int c = 0; c < 5; c++) begin
            if (done || busy) dones++;
            @(negedge clk);
        end
        n_tests += 2;
        if (dones !== 0) begin n_fail++; $display("FAIL rstmid_activity got %0d cycles want 0", dones); end
        if (cur_level !== 16'd0) begin n_fail++; $display("FAIL rstmid_level got %0d want 0", cur_level); end
    endtask

    task automatic test_back_to_back();
        logic [71:0] v = '0;
        int first = -1, second = -1, cnt = 0;
        for (int i = 0; i < NV; i++) v[3*i +: 3] = 3'b010;
        v[3*20 +: 3] = 3'b000;
        @(negedge clk); vars_value = v; start = 1;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            if (done) begin
                cnt++;
                if (first < 0) first = n; else if (second < 0) second = n;
            end
            if (n == 9) start = 0;
        end
        model_decide(20);
        model_decide(20);
        n_tests += 4;
        if (first !== 4) begin n_fail++; $display("FAIL b2b_first got %0d want 4", first); end
        if (second !== 9) begin n_fail++; $display("FAIL b2b_second got %0d want 9", second); end
        if (cnt !== 2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", cnt); end
        if (cur_level !== 16'(lvl)) begin n_fail++; $display("FAIL b2b_level got %0d want %0d", cur_level, lvl); end
    endtask

    task automatic test_saturation();
        int lat;
        for (int k = 0; k < 4; k++) begin
            run_dec(72'd0, 1, lat);
            n_tests += 3;
            if (lat !== 2) begin n_fail++; $display("FAIL sat_latency%0d got %0d want 2", k, lat); end
            if (cur_level2 !== 2'((k < 3) ? k + 1 : 3)) begin n_fail++; $display("FAIL sat_level%0d got %0d want %0d", k, cur_level2, (k < 3) ? k + 1 : 3); end
            if (level_ovf2 !== (k == 3)) begin n_fail++; $display("FAIL sat_ovf%0d got %b want %b", k, level_ovf2, k == 3); end
        end
        @(negedge clk); bkt_valid2 = 1; bkt_level2 = 2'd0;
        @(negedge clk); bkt_valid2 = 0;
        n_tests++;
        if (level_ovf2 !== 1'b0 || cur_level2 !== 2'd0) begin n_fail++; $display("FAIL sat_bkt got ovf %b lvl %0d want 0/0", level_ovf2, cur_level2); end
    endtask

    task automatic test_random();
        int lat, ff;
        logic [71:0] v;
        logic [23:0] exp_oh;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) do_phase_save(rand_vec(4));
            if ($urandom_range(0, 5) == 0) begin
                @(negedge clk); bkt_valid = 1;
                bkt_level = ($urandom_range(0, 1) == 0) ? 16'hFFFE : 16'($urandom_range(0, 100));
                lvl = int'(bkt_level); ovf = 0;
                @(negedge clk); bkt_valid = 0;
            end
            v = rand_vec(16);
            ff = first_free(v);
            exp_oh = (ff >= 0) ? (24'd1 << ff) : 24'd0;
            run_dec(v, 0, lat);
            model_decide(ff);
            n_tests += 6;
            if (lat !== exp_latency(ff)) begin n_fail++; $display("FAIL rnd%0d_latency got %0d want %0d", it, lat, exp_latency(ff)); end
            if (dec_onehot !== exp_oh) begin n_fail++; $display("FAIL rnd%0d_onehot got %h want %h", it, dec_onehot, exp_oh); end
            if (dec_idx !== 5'((ff >= 0) ? ff : 0)) begin n_fail++; $display("FAIL rnd%0d_idx got %0d want %0d", it, dec_idx, ff); end
            if (all_assigned !== (ff < 0)) begin n_fail++; $display("FAIL rnd%0d_allasg got %b want %b", it, all_assigned, ff < 0); end
            if (dec_phase !== ((ff >= 0) ? ph[ff] : 1'b0)) begin n_fail++; $display("FAIL rnd%0d_phase got %b want %b", it, dec_phase, (ff >= 0) ? ph[ff] : 1'b0); end
            if (cur_level !== 16'(lvl) || level_ovf !== ovf) begin n_fail++; $display("FAIL rnd%0d_level got %0d/%b want %0d/%b", it, cur_level, level_ovf, lvl, ovf); end
        end
    endtask

    initial begin
        test_reset();
        test_all_free();
        test_var17();
        test_all_assigned();
        test_phase_save();
        test_backtrack();
        test_back_to_back();
        test_saturation();
        test_reset_midscan();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
